filter_load_sched: RTL and testbench

- Clocked controller for the SNN filter weight store: sequences loading of a DEPTH_F x DEPTH_F 8-bit filter, then serves packed filter rows to N_PE processing elements.
- Requests are shared by round-robin arbitration.
- Sits between the weight source (file/DMA stream) and the convolution PEs; replaces direct testbench-driven addr/data loading.

---
 rtl/filter_load_sched.sv | 137 +++++++++++++
 tb/tb_filter_load_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/filter_load_sched.sv
// Filter weight store controller: loads a DEPTH_F x DEPTH_F filter, then serves packed rows
// to N_PE requesters via round-robin. Optional FILTER_CHECKSUM_EN adds a weight-sum accumulator.
module filter_load_sched #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_F    = 5,
  parameter int unsigned PACK_WIDTH = 64,
  parameter int unsigned N_PE       = 4,
  parameter int unsigned ROW_W      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic                    w_valid,
  input  logic [WIDTH-1:0]        w_data,
  output logic                    w_ready,
  output logic                    load_done,
  input  logic [N_PE-1:0]         req,
  input  logic [N_PE*ROW_W-1:0]   req_row,
  output logic [N_PE-1:0]         gnt,
  output logic                    row_valid,
  output logic [PACK_WIDTH-1:0]   row_data,
  output logic [ROW_W-1:0]        row_id,
  output logic                    busy,
  output logic [15:0]             checksum
);

  localparam int unsigned NW = DEPTH_F * DEPTH_F;
  localparam int unsigned AW = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned PW = (N_PE > 1) ? $clog2(N_PE) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StServe} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         addr_q;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [WIDTH-1:0]      mem [NW];
  logic                  accept, last;
  logic [N_PE-1:0]       gnt_d;
  logic                  found;
  logic [ROW_W-1:0]      sel_row;
  logic [PACK_WIDTH-1:0] pack;
  int                    idx;
  logic [PW-1:0]         ib;

  assign w_ready = (state_q == StLoad);
  assign busy    = (state_q == StLoad);
  assign accept  = w_valid && w_ready;
  assign last    = (addr_q == AW'(NW - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (load_start) state_d = StLoad;
      StLoad:  if (accept && last) state_d = StServe;
      StServe: if (load_start) state_d = StLoad;
      default: state_d = StIdle;
    endcase
  end

  // Round-robin search from ptr_q; a request coinciding with load_start is dropped.
  always_comb begin
    found   = 1'b0;
    gnt_d   = '0;
    sel_row = '0;
    ptr_d   = ptr_q;
    idx     = 0;
    ib      = '0;
    if (state_q == StServe && !load_start) begin
      for (int k = 0; k < int'(N_PE); k++) begin
        idx = (int'(ptr_q) + k) % int'(N_PE);
        ib  = PW'(idx);
        if (!found && req[ib]) begin
          found     = 1'b1;
          gnt_d[ib] = 1'b1;
          sel_row   = ROW_W'(req_row >> (idx * int'(ROW_W)));
          ptr_d     = PW'((idx + 1) % int'(N_PE));
        end
      end
    end
  end

  // Out-of-range rows pack to zero; bits above WIDTH*DEPTH_F stay zero.
  always_comb begin
    pack = '0;
    if (int'(sel_row) < int'(DEPTH_F)) begin
      for (int c = 0; c < int'(DEPTH_F); c++) begin
        pack[c*WIDTH +: WIDTH] = mem[AW'(int'(sel_row) * int'(DEPTH_F) + c)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      ptr_q     <= '0;
      load_done <= 1'b0;
      gnt       <= '0;
      row_valid <= 1'b0;
      row_data  <= '0;
      row_id    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      load_done <= accept && last;
      gnt       <= gnt_d;
      row_valid <= found;
      row_data  <= found ? pack : '0;
      row_id    <= found ? sel_row : '0;
      if (accept) addr_q <= last ? '0 : addr_q + AW'(1);
    end
  end

  // Weight storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) mem[addr_q] <= w_data;
  end

`ifdef FILTER_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else if (state_q != StLoad && state_d == StLoad) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + 16'(w_data);
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_filter_load_sched.sv
// Scoreboard bench for filter_load_sched: driver pushes expected rows/load_done events,
// negedge monitor pops and compares.
module tb_filter_load_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        w_valid = 1'b0;
  logic [7:0]  w_data = '0;
  logic        w_ready, load_done;
  logic [3:0]  req = '0;
  logic [11:0] req_row = '0;
  logic [3:0]  gnt;
  logic        row_valid;
  logic [63:0] row_data;
  logic [2:0]  row_id;
  logic        busy;
  logic [15:0] checksum;

  filter_load_sched dut (
    .clk       (clk),
    .rst       (rst),
    .load_start(load_start),
    .w_valid   (w_valid),
    .w_data    (w_data),
    .w_ready   (w_ready),
    .load_done (load_done),
    .req       (req),
    .req_row   (req_row),
    .gnt       (gnt),
    .row_valid (row_valid),
    .row_data  (row_data),
    .row_id    (row_id),
    .busy      (busy),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  g;
    logic [63:0] d;
    logic [2:0]  id;
  } row_exp_t;

  row_exp_t    row_q[$];
  int          done_q[$];
  logic [15:0] sum_q[$];
  row_exp_t    e;
  int          n_pass = 0;
  int          n_total = 0;
  int          nc = 0;
  int          exp_cyc;
  logic [15:0] exp_sum;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    nc++;
    if (row_valid) begin
      if (row_q.size() == 0) begin
        check("unexpected row_valid", {63'd0, row_valid}, 64'd0);
      end else begin
        e = row_q.pop_front();
        check("gnt", {60'd0, gnt}, {60'd0, e.g});
        check("row_data", row_data, e.d);
        check("row_id", {61'd0, row_id}, {61'd0, e.id});
      end
    end else if (gnt != 4'd0) begin
      check("gnt without row_valid", {60'd0, gnt}, 64'd0);
    end
    if (load_done) begin
      if (done_q.size() == 0) begin
        check("unexpected load_done", {63'd0, load_done}, 64'd0);
      end else begin
        exp_cyc = done_q.pop_front();
        exp_sum = sum_q.pop_front();
        check("load_done cycle", 64'(nc), 64'(exp_cyc));
        check("checksum", {48'd0, checksum}, {48'd0, exp_sum});
      end
    end
  end

  // Called at posedge+1; pulses load_start then streams count weights base, base+1, ...
  task automatic do_load(input int base, input bit bursty, input int count);
    int sum;
    sum = 0;
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    for (int i = 0; i < count; i++) begin
      if (bursty) begin
        w_valid = 1'b0;
        @(posedge clk); #1;
      end
      w_valid = 1'b1;
      w_data  = 8'(base + i);
      check("w_ready in load", {63'd0, w_ready}, 64'd1);
      check("busy in load", {63'd0, busy}, 64'd1);
      @(posedge clk); #1;
      sum += base + i;
    end
    w_valid = 1'b0;
    if (count == 25) begin
      done_q.push_back(nc + 1);
`ifdef FILTER_CHECKSUM_EN
      sum_q.push_back(16'(sum));
`else
      sum_q.push_back(16'd0);
`endif
      check("w_ready after load", {63'd0, w_ready}, 64'd0);
      check("busy after load", {63'd0, busy}, 64'd0);
    end
  endtask

  task automatic serve(input logic [3:0] r, input logic [11:0] rows, input int cycles);
    req     = r;
    req_row = rows;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
    req = '0;
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset w_ready", {63'd0, w_ready}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset gnt", {60'd0, gnt}, 64'd0);
    check("reset row_valid", {63'd0, row_valid}, 64'd0);
    check("reset row_data", row_data, 64'd0);
    check("reset checksum", {48'd0, checksum}, 64'd0);

    do_load(1, 1'b0, 25);

    // All four request for 8 cycles; PE rows are 0,1,3,4.
    for (int k = 0; k < 2; k++) begin
      row_q.push_back('{4'b0001, 64'h0000_0005_0403_0201, 3'd0});
      row_q.push_back('{4'b0010, 64'h0000_000A_0908_0706, 3'd1});
      row_q.push_back('{4'b0100, 64'h0000_0014_1312_1110, 3'd3});
      row_q.push_back('{4'b1000, 64'h0000_0019_1817_1615, 3'd4});
    end
    serve(4'b1111, {3'd4, 3'd3, 3'd1, 3'd0}, 8);

    row_q.push_back('{4'b0001, 64'h0000_000F_0E0D_0C0B, 3'd2});
    serve(4'b0001, 12'd2, 1);

    row_q.push_back('{4'b0100, 64'd0, 3'd7});
    serve(4'b0100, {3'd0, 3'd7, 6'd0}, 1);

    do_load(1, 1'b1, 25);
    row_q.push_back('{4'b1000, 64'h0000_0019_1817_1615, 3'd4});
    serve(4'b1000, {3'd4, 9'd0}, 1);

    // Request alongside load_start is dropped; req held through LOAD is ignored.
    req     = 4'b0001;
    req_row = 12'd1;
    do_load(50, 1'b0, 10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req = '0;
    check("mid-load reset busy", {63'd0, busy}, 64'd0);
    check("mid-load reset w_ready", {63'd0, w_ready}, 64'd0);
    serve(4'b1111, 12'd0, 3);

    do_load(101, 1'b0, 25);
    row_q.push_back('{4'b0010, 64'h0000_0069_6867_6665, 3'd0});
    serve(4'b0010, 12'd0, 1);

    repeat (4) @(posedge clk);
    #1;
    check("rows outstanding", 64'(row_q.size()), 64'd0);
    check("load_done outstanding", 64'(done_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
